// File: rtl/keypoint_stream_ctrl.sv
// Screens FAST corners by border margin and per-frame cap, queues them in a FWFT FIFO, reports frame stats.
// corner_in -> kp_valid is 1 clk; kp_ready low holds the head, and a full FIFO without a pop drops the keypoint.
module keypoint_stream_ctrl #(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720,
  parameter int COORD_W    = 11,
  parameter int BORDER     = 15,
  parameter int MAX_KP     = 1023,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vde_in,
  input  logic                          vsync_in,
  input  logic                          corner_in,
  output logic                          kp_valid,
  input  logic                          kp_ready,
  output logic [COORD_W-1:0]            kp_x,
  output logic [COORD_W-1:0]            kp_y,
  output logic                          frame_done,
  output logic                          frame_truncated,
  output logic [$clog2(MAX_KP+1)-1:0]   frame_kp_count,
  output logic [15:0]                   frame_drop_count
);

  localparam int KPC_W = $clog2(MAX_KP+1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [COORD_W-1:0] X_LO   = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] X_HI   = COORD_W'(IMG_WIDTH - 1 - BORDER);
  localparam logic [COORD_W-1:0] Y_LO   = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] Y_HI   = COORD_W'(IMG_HEIGHT - 1 - BORDER);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [KPC_W-1:0]   KP_CAP = KPC_W'(MAX_KP);
  localparam logic [CNT_W-1:0]   F_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_WAIT_SOF, S_ACTIVE, S_EOF} state_t;

  state_t               state_q, state_d;
  logic                 vsync_q;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [KPC_W-1:0]     kp_cnt_q, kp_cnt_d, fkc_q, fkc_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d, fdc_q, fdc_d;
  logic                 done_q, done_d, trunc_q, trunc_d;

  logic [2*COORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*COORD_W-1:0] head;

  logic vsync_rise, pop, push, drop, fifo_full, in_win;

  assign vsync_rise = vsync_in & ~vsync_q;
  assign kp_valid   = (cnt_q != '0);
  assign pop        = kp_valid & kp_ready;
  assign fifo_full  = (cnt_q == F_FULL);
  assign in_win     = (x_q >= X_LO) && (x_q <= X_HI) && (y_q >= Y_LO) && (y_q <= Y_HI);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    kp_cnt_d   = kp_cnt_q;
    drop_cnt_d = drop_cnt_q;
    done_d     = 1'b0;
    trunc_d    = trunc_q;
    fkc_d      = fkc_q;
    fdc_d      = fdc_q;
    push       = 1'b0;
    drop       = 1'b0;
    case (state_q)
      S_WAIT_SOF: begin
        if (vsync_rise) begin
          x_d = '0; y_d = '0; kp_cnt_d = '0; drop_cnt_d = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (vsync_rise) begin
          // Early vsync closes the old frame; this cycle's pixel belongs to neither frame.
          done_d = 1'b1; trunc_d = 1'b1;
          fkc_d = kp_cnt_q; fdc_d = drop_cnt_q;
          x_d = '0; y_d = '0; kp_cnt_d = '0; drop_cnt_d = '0;
        end else if (vde_in) begin
          if (corner_in && in_win) begin
            if (kp_cnt_q == KP_CAP)      drop = 1'b1;
            else if (fifo_full && !pop)  drop = 1'b1;
            else                         push = 1'b1;
          end
          if (push) kp_cnt_d = kp_cnt_q + KPC_W'(1);
          if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              done_d = 1'b1; trunc_d = 1'b0;
              fkc_d = kp_cnt_d; fdc_d = drop_cnt_d;
              state_d = S_EOF;
            end else begin
              y_d = y_q + COORD_W'(1);
            end
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end
      S_EOF: begin
        if (vsync_rise) begin
          x_d = '0; y_d = '0; kp_cnt_d = '0; drop_cnt_d = '0;
          state_d = S_ACTIVE;
        end else begin
          state_d = S_WAIT_SOF;
        end
      end
      default: state_d = S_WAIT_SOF;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_WAIT_SOF;
      vsync_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      kp_cnt_q   <= '0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
      fkc_q      <= '0;
      fdc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync_in;
      x_q        <= x_d;
      y_q        <= y_d;
      kp_cnt_q   <= kp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
      fkc_q      <= fkc_d;
      fdc_q      <= fdc_d;
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset: the head is masked until cnt_q says it holds data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {y_q, x_q};
  end

  assign head             = mem_q[rd_ptr_q];
  assign kp_x             = kp_valid ? head[COORD_W-1:0] : '0;
  assign kp_y             = kp_valid ? head[2*COORD_W-1:COORD_W] : '0;
  assign frame_done       = done_q;
  assign frame_truncated  = trunc_q;
  assign frame_kp_count   = fkc_q;
  assign frame_drop_count = fdc_q;

endmodule

// File: tb/tb_keypoint_stream_ctrl.sv
// Randomized and directed stimulus for keypoint_stream_ctrl, checked every cycle against a frame/queue model.
module tb_keypoint_stream_ctrl;
  localparam int W = 16, H = 8, CW = 4, B = 2, MAXKP = 4, DEPTH = 4;
  localparam int KCW = $clog2(MAXKP+1);

  logic clk = 1'b0;
  logic rst_n, vde_in, vsync_in, corner_in, kp_ready;
  logic kp_valid, frame_done, frame_truncated;
  logic [CW-1:0] kp_x, kp_y;
  logic [KCW-1:0] frame_kp_count;
  logic [15:0] frame_drop_count;

  always #5 clk = ~clk;

  keypoint_stream_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW), .BORDER(B), .MAX_KP(MAXKP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vde_in(vde_in), .vsync_in(vsync_in), .corner_in(corner_in),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y),
    .frame_done(frame_done), .frame_truncated(frame_truncated),
    .frame_kp_count(frame_kp_count), .frame_drop_count(frame_drop_count)
  );

  int n_chk = 0, n_fail = 0;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int xy(int x, int y);
    return y * 256 + x;
  endfunction

  // ---------------- reference model: pixel index + keypoint queue ----------------
  int  m_mode, m_pix, m_kpc, m_drops, m_fkc, m_fdc;
  bit  m_vs, m_done, m_trunc;
  int  mq[$];
  bit  chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit pop, rise, push, drp;
    int px, py;
    if (rst_n !== 1'b1) begin
      m_mode = 0; m_pix = 0; m_kpc = 0; m_drops = 0; m_fkc = 0; m_fdc = 0;
      m_vs = 0; m_done = 0; m_trunc = 0;
      mq.delete();
    end else begin
      pop  = (mq.size() != 0) && (kp_ready === 1'b1);
      rise = (vsync_in === 1'b1) && !m_vs;
      m_vs = (vsync_in === 1'b1);
      push = 0; drp = 0; m_done = 0; px = 0; py = 0;
      case (m_mode)
        0: if (rise) begin m_pix = 0; m_kpc = 0; m_drops = 0; m_mode = 1; end
        1: begin
          if (rise) begin
            m_done = 1; m_trunc = 1; m_fkc = m_kpc; m_fdc = m_drops;
            m_pix = 0; m_kpc = 0; m_drops = 0;
          end else if (vde_in === 1'b1) begin
            px = m_pix % W; py = m_pix / W;
            if (corner_in === 1'b1 && px >= B && px <= W-1-B && py >= B && py <= H-1-B) begin
              if (m_kpc == MAXKP) drp = 1;
              else if (mq.size() == DEPTH && !pop) drp = 1;
              else push = 1;
            end
            if (push) m_kpc++;
            if (drp && m_drops < 65535) m_drops++;
            if (m_pix == W*H-1) begin
              m_done = 1; m_trunc = 0; m_fkc = m_kpc; m_fdc = m_drops; m_mode = 2;
            end else m_pix++;
          end
        end
        default: begin
          if (rise) begin m_pix = 0; m_kpc = 0; m_drops = 0; m_mode = 1; end
          else m_mode = 0;
        end
      endcase
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(xy(px, py));
    end
  end

  // ---------------- compare process + event recording ----------------
  typedef struct { int t; int kc; int dc; } ev_t;
  ev_t ev[$];
  int  got[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("kp_valid", int'(kp_valid), int'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("kp_x", int'(kp_x), mq[0] % 256);
        check("kp_y", int'(kp_y), mq[0] / 256);
      end
      check("frame_done", int'(frame_done), int'(m_done));
      if (m_done) check("frame_truncated", int'(frame_truncated), int'(m_trunc));
      check("frame_kp_count", int'(frame_kp_count), m_fkc);
      check("frame_drop_count", int'(frame_drop_count), m_fdc);
      if (frame_done === 1'b1) ev.push_back('{int'(frame_truncated), int'(frame_kp_count), int'(frame_drop_count)});
      if (kp_valid === 1'b1 && kp_ready === 1'b1) got.push_back(xy(int'(kp_x), int'(kp_y)));
    end
  end

  function automatic int got_at(int i);
    return (got.size() > i) ? got[i] : -1;
  endfunction

  function automatic ev_t ev_at(int i);
    ev_t e;
    e = '{-1, -1, -1};
    if (ev.size() > i) e = ev[i];
    return e;
  endfunction

  // ---------------- stimulus ----------------
  bit cmap[W*H];
  int rdy_mode = 1;
  int rdy_pulse_pix = -1;

  task automatic cyc(input logic v, input logic s, input logic c, input int p);
    vde_in = v; vsync_in = s; corner_in = c;
    if (p >= 0 && p == rdy_pulse_pix) kp_ready = 1'b1;
    else if (rdy_mode == 2)           kp_ready = 1'($urandom_range(0, 1));
    else                              kp_ready = (rdy_mode == 1);
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic clr_map();
    for (int i = 0; i < W*H; i++) cmap[i] = 1'b0;
  endtask

  task automatic set_c(input int x, input int y);
    cmap[y*W + x] = 1'b1;
  endtask

  task automatic run_frame(input int npix, input int gap);
    cyc(1'b0, 1'b1, 1'b0, -1);
    for (int p = 0; p < npix; p++) begin
      repeat ($urandom_range(0, gap)) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), -1);
      cyc(1'b1, 1'b0, cmap[p], p);
    end
  endtask

  initial begin
    ev_t e;
    rst_n = 1'b0; vde_in = 1'b0; vsync_in = 1'b0; corner_in = 1'b0; kp_ready = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, -1);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, -1);
    rst_n = 1'b1;
    check("rst_kp_valid", int'(kp_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_kp_count", int'(frame_kp_count), 0);
    check("rst_drop_count", int'(frame_drop_count), 0);
    check("rst_kp_x", int'(kp_x), 0);

    // single keypoint, full frame
    rdy_mode = 1; clr_map(); set_c(5, 3); ev.delete(); got.delete();
    run_frame(W*H, 0); idle(3);
    e = ev_at(0);
    check("t1_events", ev.size(), 1);
    check("t1_trunc", e.t, 0); check("t1_count", e.kc, 1); check("t1_drop", e.dc, 0);
    check("t1_got_n", got.size(), 1); check("t1_kp", got_at(0), xy(5, 3));

    // out-of-window corners
    clr_map(); set_c(1, 3); set_c(14, 3); set_c(5, 0); set_c(5, 6); ev.delete(); got.delete();
    run_frame(W*H, 1); idle(3);
    e = ev_at(0);
    check("t2_count", e.kc, 0); check("t2_drop", e.dc, 0); check("t2_got_n", got.size(), 0);

    // window edges: inclusive on both sides
    clr_map(); set_c(2, 1); set_c(1, 2); set_c(2, 2); set_c(13, 2); set_c(2, 5); set_c(13, 5);
    set_c(14, 5); set_c(13, 6); ev.delete(); got.delete();
    run_frame(W*H, 0); idle(3);
    e = ev_at(0);
    check("t2b_count", e.kc, 4); check("t2b_drop", e.dc, 0);
    check("t2b_first", got_at(0), xy(2, 2)); check("t2b_last", got_at(3), xy(13, 5));

    // per-frame cap
    clr_map(); set_c(3, 2); set_c(7, 2); set_c(4, 3); set_c(10, 4); set_c(2, 5); set_c(12, 5);
    ev.delete(); got.delete();
    run_frame(W*H, 1); idle(3);
    e = ev_at(0);
    check("t3_count", e.kc, 4); check("t3_drop", e.dc, 2); check("t3_got_n", got.size(), 4);
    check("t3_kp0", got_at(0), xy(3, 2)); check("t3_kp3", got_at(3), xy(10, 4));

    // FIFO overflow with consumer stalled, then drain
    rdy_mode = 0; ev.delete(); got.delete();
    clr_map(); set_c(3, 2); set_c(4, 2); set_c(5, 2); run_frame(W*H, 0); idle(2);
    clr_map(); set_c(3, 3); set_c(4, 3); set_c(5, 3); run_frame(W*H, 0); idle(2);
    e = ev_at(1);
    check("t4_count", e.kc, 1); check("t4_drop", e.dc, 2);
    rdy_mode = 1; idle(8);
    check("t4_got_n", got.size(), 4);
    check("t4_kp0", got_at(0), xy(3, 2)); check("t4_kp3", got_at(3), xy(3, 3));
    check("t4_empty", int'(kp_valid), 0);

    // push and pop together on a full FIFO
    rdy_mode = 0; ev.delete(); got.delete();
    clr_map(); set_c(3, 2); set_c(4, 2); set_c(5, 2); run_frame(W*H, 0); idle(2);
    clr_map(); set_c(3, 4); set_c(4, 4); rdy_pulse_pix = 4*W + 4; run_frame(W*H, 0); idle(2);
    rdy_pulse_pix = -1;
    e = ev_at(1);
    check("t4b_count", e.kc, 2); check("t4b_drop", e.dc, 0);
    rdy_mode = 1; idle(8);
    check("t4b_got_n", got.size(), 5); check("t4b_kp4", got_at(4), xy(4, 4));

    // truncated frame, then a fresh frame
    ev.delete(); got.delete();
    clr_map(); set_c(4, 2); run_frame(5*W, 0);
    clr_map(); set_c(5, 3); run_frame(W*H, 0); idle(3);
    e = ev_at(0);
    check("t5_trunc", e.t, 1); check("t5_count", e.kc, 1);
    e = ev_at(1);
    check("t5_next_trunc", e.t, 0); check("t5_next_count", e.kc, 1);
    check("t5_kp_new", got_at(1), xy(5, 3));

    // reset mid-frame with queued keypoints
    rdy_mode = 0; clr_map(); set_c(3, 2); set_c(4, 2); set_c(5, 2);
    run_frame(4*W, 0);
    rst_n = 1'b0; cyc(1'b0, 1'b0, 1'b0, -1); rst_n = 1'b1;
    check("t6_kp_valid", int'(kp_valid), 0);
    check("t6_kp_count", int'(frame_kp_count), 0);
    check("t6_frame_done", int'(frame_done), 0);
    rdy_mode = 1; got.delete();
    repeat (2*W) cyc(1'b1, 1'b0, 1'b1, -1);
    idle(2);
    check("t6_ignored", got.size(), 0);

    // randomized frames: truncations, back-to-back vsync at EOF, random backpressure
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < W*H; i++) cmap[i] = ($urandom_range(0, 3) == 0);
      rdy_mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : 2;
      run_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W*H-1)) : W*H,
                int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 3)));
    end
    rdy_mode = 1; idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
